// File: rtl/shooter_engine_if.sv
// Bus between the shooter game-state core (slave) and the game controller / renderer side (master).
interface shooter_engine_if #(
    parameter int N_BULLETS = 4,
    parameter int N_ENEMIES = 10
);
    logic                      tick;
    logic [9:0]                player_x;
    logic [9:0]                player_y;
    logic                      fire;
    logic signed [3:0]         fire_dx;
    logic signed [3:0]         fire_dy;
    logic                      busy;
    logic                      frame_done;
    logic                      fire_pulse;
    logic                      hit_pulse;
    logic [10*N_BULLETS-1:0]   bullet_x;
    logic [10*N_BULLETS-1:0]   bullet_y;
    logic [N_BULLETS-1:0]      bullet_active;
    logic [10*N_ENEMIES-1:0]   enemy_x;
    logic [10*N_ENEMIES-1:0]   enemy_y;
    logic [N_ENEMIES-1:0]      enemy_active;
    logic [7:0]                score_bcd;

    modport master (
        output tick, player_x, player_y, fire, fire_dx, fire_dy,
        input  busy, frame_done, fire_pulse, hit_pulse,
               bullet_x, bullet_y, bullet_active,
               enemy_x, enemy_y, enemy_active, score_bcd
    );

    modport slave (
        input  tick, player_x, player_y, fire, fire_dx, fire_dy,
        output busy, frame_done, fire_pulse, hit_pulse,
               bullet_x, bullet_y, bullet_active,
               enemy_x, enemy_y, enemy_active, score_bcd
    );
endinterface

// File: rtl/shooter_engine.sv
// VGA shooter world core: bullet/enemy pools advanced once per frame tick by a sequential update FSM.
// Optional build macro SHOOTER_ENEMY_DRIFT_EN makes active enemies step toward the player each tick.
module shooter_engine #(
    parameter int N_BULLETS    = 4,
    parameter int N_ENEMIES    = 10,
    parameter int SCR_W        = 640,
    parameter int SCR_H        = 480,
    parameter int OBJ_SIZE     = 20,
    parameter int BUL_W        = 5,
    parameter int BUL_H        = 10,
    parameter int SPAWN_PERIOD = 32
) (
    input logic             clk,
    input logic             rst,
    shooter_engine_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FIRE    = 3'd1;
    localparam logic [2:0] S_MOVE    = 3'd2;
    localparam logic [2:0] S_COLLIDE = 3'd3;
    localparam logic [2:0] S_SPAWN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int BI_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
    localparam int EI_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
    localparam int SC_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [BI_W-1:0]    B_LAST     = BI_W'(N_BULLETS - 1);
    localparam logic [EI_W-1:0]    E_LAST     = EI_W'(N_ENEMIES - 1);
    localparam logic [SC_W-1:0]    SPAWN_LAST = SC_W'(SPAWN_PERIOD - 1);
    localparam logic signed [10:0] X_MAX      = 11'(SCR_W - BUL_W);
    localparam logic signed [10:0] Y_MAX      = 11'(SCR_H - BUL_H);
    localparam logic [10:0]        OBJ_EXT    = 11'(OBJ_SIZE);
    localparam logic [10:0]        BW_EXT     = 11'(BUL_W);
    localparam logic [10:0]        BH_EXT     = 11'(BUL_H);
    localparam logic [9:0]         X_RANGE    = 10'(SCR_W - OBJ_SIZE);
    localparam logic [9:0]         Y_RANGE    = 10'(SCR_H - OBJ_SIZE);
    localparam logic [19:0]        LFSR_SEED  = 20'h5A5A5;

    logic [2:0]           state;
    logic [9:0]           bul_x  [N_BULLETS];
    logic [9:0]           bul_y  [N_BULLETS];
    logic signed [3:0]    bul_vx [N_BULLETS];
    logic signed [3:0]    bul_vy [N_BULLETS];
    logic [N_BULLETS-1:0] bul_act;
    logic [9:0]           en_x   [N_ENEMIES];
    logic [9:0]           en_y   [N_ENEMIES];
    logic [N_ENEMIES-1:0] en_act;
    logic [BI_W-1:0]      b_idx;
    logic [EI_W-1:0]      e_idx;
    logic                 fire_prev;
    logic [SC_W-1:0]      spawn_cnt;
    logic [19:0]          lfsr;
    logic [7:0]           score;
    logic                 busy_q;
    logic                 frame_done_q;
    logic                 fire_pulse_q;
    logic                 hit_pulse_q;

    logic                 free_found;
    logic [BI_W-1:0]      free_idx;
    logic                 empty_found;
    logic [EI_W-1:0]      empty_idx;
    logic                 fire_ok;
    logic signed [10:0]   nx [N_BULLETS];
    logic signed [10:0]   ny [N_BULLETS];
    logic [N_BULLETS-1:0] off_screen;
    logic [10:0]          hb_x, hb_y, he_x, he_y;
    logic                 pair_hit;
    logic [7:0]           score_inc;
    logic [9:0]           drift_x [N_ENEMIES];
    logic [9:0]           drift_y [N_ENEMIES];

    // Lowest-index free bullet slot and lowest-index inactive enemy slot.
    always_comb begin
        // NOTE: every variable of a combinational block gets a default first so no path can infer a latch.
        free_found  = 1'b0;
        free_idx    = '0;
        empty_found = 1'b0;
        empty_idx   = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!bul_act[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = BI_W'(i);
            end
        end
        for (int e = 0; e < N_ENEMIES; e++) begin
            if (!en_act[e] && !empty_found) begin
                empty_found = 1'b1;
                empty_idx   = EI_W'(e);
            end
        end
    end

    assign fire_ok = bus.fire && !fire_prev && free_found
                  && ((bus.fire_dx != 4'sd0) || (bus.fire_dy != 4'sd0));

    // Next positions in 11-bit signed so that both screen edges are visible as plain compares.
    always_comb begin
        off_screen = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            nx[i] = $signed({1'b0, bul_x[i]}) + 11'(bul_vx[i]);
            ny[i] = $signed({1'b0, bul_y[i]}) + 11'(bul_vy[i]);
            off_screen[i] = nx[i][10] || ny[i][10] || (nx[i] > X_MAX) || (ny[i] > Y_MAX);
        end
    end

    always_comb begin
        hb_x = {1'b0, bul_x[b_idx]};
        hb_y = {1'b0, bul_y[b_idx]};
        he_x = {1'b0, en_x[e_idx]};
        he_y = {1'b0, en_y[e_idx]};
        pair_hit = bul_act[b_idx] && en_act[e_idx]
                && (hb_x < he_x + OBJ_EXT) && (hb_x + BW_EXT > he_x)
                && (hb_y < he_y + OBJ_EXT) && (hb_y + BH_EXT > he_y);
    end

    always_comb begin
        if (score == 8'h99) begin
            score_inc = 8'h99;
        end else if (score[3:0] == 4'd9) begin
            score_inc = {score[7:4] + 4'd1, 4'd0};
        end else begin
            score_inc = {score[7:4], score[3:0] + 4'd1};
        end
    end

    always_comb begin
        for (int e = 0; e < N_ENEMIES; e++) begin
            drift_x[e] = en_x[e];
            drift_y[e] = en_y[e];
`ifdef SHOOTER_ENEMY_DRIFT_EN
            if (en_act[e]) begin
                if (en_x[e] < bus.player_x)      drift_x[e] = en_x[e] + 10'd1;
                else if (en_x[e] > bus.player_x) drift_x[e] = en_x[e] - 10'd1;
                if (en_y[e] < bus.player_y)      drift_y[e] = en_y[e] + 10'd1;
                else if (en_y[e] > bus.player_y) drift_y[e] = en_y[e] - 10'd1;
            end
`else
            drift_x[e] = en_x[e] ^ 10'd0;
            drift_y[e] = en_y[e] ^ 10'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the position/flag arrays are reset because they are visible outputs that must read 0.
            state        <= S_IDLE;
            bul_act      <= '0;
            en_act       <= '0;
            b_idx        <= '0;
            e_idx        <= '0;
            fire_prev    <= 1'b0;
            spawn_cnt    <= '0;
            lfsr         <= LFSR_SEED;
            score        <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            fire_pulse_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            for (int i = 0; i < N_BULLETS; i++) begin
                bul_x[i]  <= '0;
                bul_y[i]  <= '0;
                bul_vx[i] <= '0;
                bul_vy[i] <= '0;
            end
            for (int e = 0; e < N_ENEMIES; e++) begin
                en_x[e] <= '0;
                en_y[e] <= '0;
            end
        end else begin
            // NOTE: non-blocking only, so every branch below reads the pre-edge values of the pools.
            lfsr         <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
            frame_done_q <= 1'b0;
            fire_pulse_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.tick) begin
                        state  <= S_FIRE;
                        busy_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    fire_prev <= bus.fire;
                    if (fire_ok) begin
                        bul_x[free_idx]   <= bus.player_x + 10'd10;
                        bul_y[free_idx]   <= bus.player_y;
                        bul_vx[free_idx]  <= bus.fire_dx;
                        bul_vy[free_idx]  <= bus.fire_dy;
                        bul_act[free_idx] <= 1'b1;
                        fire_pulse_q      <= 1'b1;
                    end
                    state <= S_MOVE;
                end
                S_MOVE: begin
                    for (int i = 0; i < N_BULLETS; i++) begin
                        if (bul_act[i]) begin
                            if (off_screen[i]) begin
                                bul_act[i] <= 1'b0;
                            end else begin
                                bul_x[i] <= nx[i][9:0];
                                bul_y[i] <= ny[i][9:0];
                            end
                        end
                    end
                    b_idx <= '0;
                    e_idx <= '0;
                    state <= S_COLLIDE;
                end
                S_COLLIDE: begin
                    if (pair_hit) begin
                        bul_act[b_idx] <= 1'b0;
                        en_act[e_idx]  <= 1'b0;
                        score          <= score_inc;
                        hit_pulse_q    <= 1'b1;
                    end
                    if (e_idx == E_LAST) begin
                        e_idx <= '0;
                        if (b_idx == B_LAST) begin
                            b_idx <= '0;
                            state <= S_SPAWN;
                        end else begin
                            b_idx <= b_idx + 1'b1;
                        end
                    end else begin
                        e_idx <= e_idx + 1'b1;
                    end
                end
                S_SPAWN: begin
                    for (int e = 0; e < N_ENEMIES; e++) begin
                        en_x[e] <= drift_x[e];
                        en_y[e] <= drift_y[e];
                    end
                    // A freshly spawned enemy overrides its slot's drift value, so it does not move this tick.
                    if (spawn_cnt == SPAWN_LAST) begin
                        spawn_cnt <= '0;
                        if (empty_found) begin
                            en_x[empty_idx]   <= lfsr[9:0] % X_RANGE;
                            en_y[empty_idx]   <= lfsr[19:10] % Y_RANGE;
                            en_act[empty_idx] <= 1'b1;
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt + 1'b1;
                    end
                    frame_done_q <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    logic [10*N_BULLETS-1:0] bullet_x_flat, bullet_y_flat;
    logic [10*N_ENEMIES-1:0] enemy_x_flat, enemy_y_flat;

    always_comb begin
        bullet_x_flat = '0;
        bullet_y_flat = '0;
        enemy_x_flat  = '0;
        enemy_y_flat  = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            bullet_x_flat[10*i +: 10] = bul_x[i];
            bullet_y_flat[10*i +: 10] = bul_y[i];
        end
        for (int e = 0; e < N_ENEMIES; e++) begin
            enemy_x_flat[10*e +: 10] = en_x[e];
            enemy_y_flat[10*e +: 10] = en_y[e];
        end
    end

    assign bus.busy          = busy_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.fire_pulse    = fire_pulse_q;
    assign bus.hit_pulse     = hit_pulse_q;
    assign bus.bullet_x      = bullet_x_flat;
    assign bus.bullet_y      = bullet_y_flat;
    assign bus.bullet_active = bul_act;
    assign bus.enemy_x       = enemy_x_flat;
    assign bus.enemy_y       = enemy_y_flat;
    assign bus.enemy_active  = en_act;
    assign bus.score_bcd     = score;
endmodule

// File: tb/tb_shooter_engine.sv
// Directed bench for shooter_engine: a default instance for fire/move/timing and a
// SPAWN_PERIOD=1 instance for spawning, kills, BCD scoring and reset mid-update.
module tb_shooter_engine;
    localparam int NB = 4;
    localparam int NE = 10;
    localparam int P  = NB * NE;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    shooter_engine_if #(.N_BULLETS(NB), .N_ENEMIES(NE)) ifa ();
    shooter_engine_if #(.N_BULLETS(NB), .N_ENEMIES(NE)) ifb ();

    shooter_engine #(.N_BULLETS(NB), .N_ENEMIES(NE)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    shooter_engine #(.N_BULLETS(NB), .N_ENEMIES(NE), .SPAWN_PERIOD(1)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;
    int n_fire, n_hit, n_done, fire_at, hit_at, done_at, busy_bad;
    logic [19:0] spawn_lfsr;

    // Reference LFSR for instance B: 20-bit Fibonacci, taps 20 and 17, seeded under reset.
    logic [19:0] m_lfsr;
    always @(posedge clk) begin
        if (rst_b) m_lfsr <= 20'h5A5A5;
        else       m_lfsr <= {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
    end

    logic [9:0]    mex [NE];
    logic [9:0]    mey [NE];
    logic [NE-1:0] mea;
    int            hits;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted tick; samples every cycle of the update until the first idle cycle.
    task automatic run_tick(input bit use_b);
        logic bs, fd, fp, hp;
        n_fire = 0; n_hit = 0; n_done = 0; busy_bad = 0;
        fire_at = -1; hit_at = -1; done_at = -1;
        @(negedge clk);
        if (use_b) ifb.tick = 1'b1; else ifa.tick = 1'b1;
        @(negedge clk);
        ifa.tick = 1'b0;
        ifb.tick = 1'b0;
        for (int k = 1; k <= P + 5; k++) begin
            if (use_b) begin
                bs = ifb.busy; fd = ifb.frame_done; fp = ifb.fire_pulse; hp = ifb.hit_pulse;
            end else begin
                bs = ifa.busy; fd = ifa.frame_done; fp = ifa.fire_pulse; hp = ifa.hit_pulse;
            end
            if (bs !== (k <= P + 4)) busy_bad++;
            if (fd === 1'b1) begin n_done++; done_at = k; end
            if (fp === 1'b1) begin n_fire++; fire_at = k; end
            if (hp === 1'b1) begin n_hit++;  hit_at  = k; end
            if (k == P + 3) spawn_lfsr = m_lfsr;
            if (k < P + 5) @(negedge clk);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic model_clear();
        mea  = '0;
        hits = 0;
        for (int e = 0; e < NE; e++) begin
            mex[e] = '0;
            mey[e] = '0;
        end
    endtask

    task automatic model_spawn(input logic [19:0] l);
        for (int e = 0; e < NE; e++) begin
            if (!mea[e]) begin
                mex[e] = l[9:0] % 10'd620;
                mey[e] = l[19:10] % 10'd460;
                mea[e] = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_enemies(input string tag);
        logic [10*NE-1:0] ex, ey;
        for (int e = 0; e < NE; e++) begin
            ex[10*e +: 10] = mex[e];
            ey[10*e +: 10] = mey[e];
        end
        check({tag, "_active"}, ifb.enemy_active, mea);
        check({tag, "_x"}, ifb.enemy_x, ex);
        check({tag, "_y"}, ifb.enemy_y, ey);
    endtask

    initial begin
        int tgt;
        int fires;
        logic [7:0] exp_score;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.tick = 1'b0; ifa.fire = 1'b0; ifa.fire_dx = 4'sd0; ifa.fire_dy = 4'sd0;
        ifa.player_x = 10'd0; ifa.player_y = 10'd0;
        ifb.tick = 1'b0; ifb.fire = 1'b0; ifb.fire_dx = 4'sd0; ifb.fire_dy = 4'sd0;
        ifb.player_x = 10'd0; ifb.player_y = 10'd0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;

        // Reset state and an idle update.
        check("rst_busy", ifa.busy, 1'b0);
        check("rst_frame_done", ifa.frame_done, 1'b0);
        check("rst_bullet_x", ifa.bullet_x, 40'd0);
        check("rst_bullet_active", ifa.bullet_active, 4'd0);
        check("rst_score", ifa.score_bcd, 8'h00);
        run_tick(1'b0);
        check("idle_done_at", done_at, 44);
        check("idle_done_count", n_done, 1);
        check("idle_busy_window", busy_bad, 0);
        check("idle_no_fire", n_fire, 0);
        check("idle_no_hit", n_hit, 0);
        check("idle_bullet_active", ifa.bullet_active, 4'd0);
        check("idle_enemy_active", ifa.enemy_active, 10'd0);
        check("idle_score", ifa.score_bcd, 8'h00);

        // Rising fire launches once; held fire does not relaunch.
        reset_a();
        ifa.player_x = 10'd100; ifa.player_y = 10'd200;
        ifa.fire_dx = 4'sd3; ifa.fire_dy = 4'sd0; ifa.fire = 1'b1;
        run_tick(1'b0);
        check("launch_pulses", n_fire, 1);
        check("launch_pulse_cycle", fire_at, 2);
        check("launch_x", ifa.bullet_x[9:0], 10'd113);
        check("launch_y", ifa.bullet_y[9:0], 10'd200);
        check("launch_active", ifa.bullet_active, 4'b0001);
        fires = 0;
        for (int t = 0; t < 3; t++) begin
            run_tick(1'b0);
            fires += n_fire;
        end
        check("held_no_relaunch", fires, 0);
        check("held_x", ifa.bullet_x[9:0], 10'd122);
        check("held_active", ifa.bullet_active, 4'b0001);

        // Five rising edges fill the four slots; the fifth finds the pool full.
        reset_a();
        ifa.fire_dx = 4'sd0; ifa.fire_dy = -4'sd1;
        for (int t = 0; t < 9; t++) begin
            ifa.fire = (t % 2 == 0);
            run_tick(1'b0);
            if (t % 2 == 0) check($sformatf("pool_attempt%0d", t / 2), n_fire, (t < 8) ? 1 : 0);
        end
        check("pool_active", ifa.bullet_active, 4'hF);
        check("pool_x", ifa.bullet_x, {4{10'd110}});
        check("pool_y", ifa.bullet_y, {10'd197, 10'd195, 10'd193, 10'd191});
        check("pool_no_spawn", ifa.enemy_active, 10'd0);

        // Right-edge boundary: 633+3 leaves the screen, 632+3 lands exactly on the limit.
        reset_a();
        ifa.player_x = 10'd620; ifa.player_y = 10'd200;
        ifa.fire_dx = 4'sd3; ifa.fire_dy = 4'sd0; ifa.fire = 1'b1;
        run_tick(1'b0);
        check("edge633_x", ifa.bullet_x[9:0], 10'd633);
        check("edge633_active", ifa.bullet_active, 4'b0001);
        run_tick(1'b0);
        check("edge633_gone", ifa.bullet_active, 4'b0000);
        check("edge633_x_kept", ifa.bullet_x[9:0], 10'd633);
        ifa.fire = 1'b0;
        run_tick(1'b0);
        ifa.fire = 1'b1; ifa.player_x = 10'd619;
        run_tick(1'b0);
        check("edge632_x", ifa.bullet_x[9:0], 10'd632);
        run_tick(1'b0);
        check("edge635_x", ifa.bullet_x[9:0], 10'd635);
        check("edge635_active", ifa.bullet_active, 4'b0001);

        // Instance B: a spawn every tick; each fire tick aims at the lowest active enemy.
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        model_clear();
        ifb.fire_dx = 4'sd0; ifb.fire_dy = -4'sd1; ifb.fire = 1'b0;
        run_tick(1'b1);
        model_spawn(spawn_lfsr);
        check("first_spawn_e0", ifb.enemy_active[0], 1'b1);
        check_enemies("first_spawn");
        for (int h = 1; h <= 100; h++) begin
            tgt = 0;
            while (!mea[tgt]) tgt++;
            ifb.player_x = mex[tgt] - 10'd5;
            ifb.player_y = mey[tgt] + 10'd6;
            ifb.fire = 1'b1;
            run_tick(1'b1);
            mea[tgt] = 1'b0;
            hits++;
            model_spawn(spawn_lfsr);
            exp_score = (hits >= 99) ? 8'h99 : 8'(((hits / 10) << 4) | (hits % 10));
            check($sformatf("hit%0d_fire", h), n_fire, 1);
            check($sformatf("hit%0d_pulses", h), n_hit, 1);
            check($sformatf("hit%0d_cycle", h), hit_at, 4 + tgt);
            check($sformatf("hit%0d_bullet_cleared", h), ifb.bullet_active, 4'd0);
            check($sformatf("hit%0d_score", h), ifb.score_bcd, exp_score);
            check_enemies($sformatf("hit%0d", h));
            ifb.fire = 1'b0;
            run_tick(1'b1);
            model_spawn(spawn_lfsr);
            check_enemies($sformatf("rearm%0d", h));
        end
        check("score_saturated", ifb.score_bcd, 8'h99);

        // Reset in the middle of COLLIDE aborts the update; the next tick runs in full.
        ifb.fire = 1'b0;
        @(negedge clk);
        ifb.tick = 1'b1;
        @(negedge clk);
        ifb.tick = 1'b0;
        repeat (4) @(negedge clk);
        check("collide_busy", ifb.busy, 1'b1);
        rst_b = 1'b1;
        @(negedge clk);
        check("abort_busy", ifb.busy, 1'b0);
        check("abort_frame_done", ifb.frame_done, 1'b0);
        check("abort_bullet_x", ifb.bullet_x, 40'd0);
        check("abort_enemy_x", ifb.enemy_x, 100'd0);
        check("abort_enemy_y", ifb.enemy_y, 100'd0);
        check("abort_enemy_active", ifb.enemy_active, 10'd0);
        check("abort_score", ifb.score_bcd, 8'h00);
        rst_b = 1'b0;
        model_clear();
        run_tick(1'b1);
        model_spawn(spawn_lfsr);
        check("after_abort_done_at", done_at, 44);
        check("after_abort_done_count", n_done, 1);
        check("after_abort_busy_window", busy_bad, 0);
        check_enemies("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shooter_engine.md
# shooter_engine

Parametrised game-state core for the VGA shooter. It owns a pool of bullets and a pool of enemies, and advances the whole world once per frame tick through a sequential update FSM. Each update covers fire, movement, pairwise collision, timed spawning and a BCD score. Positions and active flags go out as packed vectors to the VGA renderer; one-cycle event pulses go to the sound-effect block.

## Interface
- N_BULLETS, 4, bullet pool size (≥1)
- N_ENEMIES, 10, enemy pool size (≥1)
- SCR_W, 640, screen width in pixels
- SCR_H, 480, screen height in pixels
- OBJ_SIZE, 20, enemy/player square side
- BUL_W, 5, bullet width
- BUL_H, 10, bullet height
- SPAWN_PERIOD, 32, ticks between spawn attempts (≥1)
- clk  in  1  system clock; the single clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle frame strobe; starts one world update
- player_x, player_y  in  10 each  player top-left corner
- fire  in  1  fire request, level
- fire_dx, fire_dy  in  4 each, signed  bullet velocity in pixels per tick
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse at the end of an update
- fire_pulse  out  1  one-cycle pulse when a bullet is launched
- hit_pulse  out  1  one-cycle pulse per bullet/enemy kill
- bullet_x, bullet_y  out  10*N_BULLETS each  packed positions; slot i is bits [10i+9:10i]
- bullet_active  out  N_BULLETS  per-slot active flag
- enemy_x, enemy_y  out  10*N_ENEMIES each  packed positions
- enemy_active  out  N_ENEMIES  per-slot active flag
- score_bcd  out  8  two BCD digits, saturating at 0x99

## Operation
- FSM states: IDLE → FIRE → MOVE → COLLIDE → SPAWN → DONE → IDLE.
- **IDLE**
  - A tick moves the FSM to FIRE.
  - A tick arriving in any other state is dropped.
- **FIRE**
  - Firing occurs when all of these hold:
    - fire=1 and fire_prev=0, where fire_prev is fire as sampled at the previous accepted tick;
    - (fire_dx, fire_dy) ≠ (0, 0);
    - at least one bullet slot is free.
  - On firing, the lowest-index free slot is loaded: x = player_x+10, y = player_y, velocity latched, active=1.
  - fire_pulse is asserted on firing.
  - fire_prev is updated in FIRE on every accepted tick.
- **MOVE**
  - Every active bullet is updated, including one launched this tick.
  - The next position is computed in 11-bit signed arithmetic.
  - If next x < 0, x > SCR_W−BUL_W, y < 0 or y > SCR_H−BUL_H, the bullet is deactivated and its position left unchanged.
  - Otherwise the next position is written back.
- **COLLIDE**
  - One (bullet b, enemy e) pair is checked per cycle, e as the inner index, for N_BULLETS*N_ENEMIES cycles.
  - A hit requires both objects active and: bx < ex+OBJ_SIZE, bx+BUL_W > ex, by < ey+OBJ_SIZE, by+BUL_H > ey.
  - On a hit:
    - both the bullet and the enemy are deactivated, visible to the next pair;
    - score_bcd is incremented in BCD (0x09→0x10), holding at 0x99;
    - hit_pulse is asserted, including when the score is saturated.
  - Because flags update immediately, a bullet kills at most one enemy: the lowest index hit.
- **SPAWN**
  - spawn_cnt counts accepted ticks and wraps at SPAWN_PERIOD−1.
  - On the wrap cycle, the lowest-index inactive enemy is loaded:
    - x = lfsr[9:0] mod (SCR_W−OBJ_SIZE), exact remainder;
    - y = lfsr[19:10] mod (SCR_H−OBJ_SIZE), exact remainder;
    - active=1.
  - If the enemy pool is full, no spawn occurs; spawn_cnt still wraps.
- **LFSR**
  - 20-bit Fibonacci, taps 20,17.
  - Advances every clk cycle.
  - Seed 20'h5A5A5; never reaches zero.
- **DONE**: frame_done is asserted and the FSM returns to IDLE.
- **Reset**
  - All outputs are 0, score_bcd=0x00, FSM in IDLE, spawn_cnt=0, fire_prev=0, velocities 0, LFSR at seed.
  - Reset asserted in any state aborts the update on the next edge.

## Timing
- A tick sampled at cycle T produces: FIRE at T+1, MOVE at T+2, COLLIDE at T+3 .. T+2+P with P = N_BULLETS*N_ENEMIES, SPAWN at T+3+P, DONE at T+4+P.
- Default parameters: frame_done at T+44; busy high T+1..T+44.
- Outputs are registered.
  - fire_pulse is high in the cycle after FIRE.
  - hit_pulse is high in the cycle after the hitting pair.
  - Vectors reflect each update one cycle after the state that wrote them.
- The earliest next accepted tick is T+5+P, in IDLE.

## Configuration
- SHOOTER_ENEMY_DRIFT_EN defined: in SPAWN, on every tick, each enemy active at entry steps 1 pixel toward the player on each axis independently.
  - No step on an axis where positions are already equal.
  - The step is applied before the spawn check, so a newly spawned enemy does not move that tick.
- Not defined: enemies are stationary once spawned. Timing is identical in both builds.

## Test plan
- Reset, then one tick with fire=0 → frame_done exactly at T+44; all active flags 0; score_bcd=0x00; no pulses.
- Player (100,200), fire rising with dx=+3, dy=0 → one fire_pulse; slot 0 at x=113, y=200. Holding fire=1 for 3 more ticks → no further launches; x reaches 122.
- dx=0, dy=−1 with fire toggled on 5 consecutive ticks (fire high on every other tick) → four fire_pulses filling slots 0..3; the fifth attempt gives no pulse, pool full.
- Bullet at x=633 with dx=+3 → deactivated on the next MOVE, x remains 633. A bullet at x=632 moves to 635 and stays active.
- SPAWN_PERIOD=1; run ticks until enemy 0 is active; place player so a bullet lands inside the enemy 0 box → one hit_pulse, both flags cleared.
  - Preload score 0x09 → becomes 0x10.
  - At 0x99 → stays 0x99 and hit_pulse still fires.
- Assert rst during COLLIDE → next cycle busy=0, all vectors 0, score 0x00. A following tick runs a full 44-cycle update.
